adder_seq_ctrl: RTL

Sequencing controller that performs wide add/subtract operations by iterating a single 4-bit add-with-carry slice over the operands, one nibble per clock, least-significant nibble first. It sits between a requester that issues start/operand commands and the downstream logic that consumes the result. It is the multi-cycle, resource-sharing counterpart to the team's combinational 4-bit adder: one nibble slice is reused instead of replicating adders across the width.

---
 rtl/adder_seq_ctrl.sv | 107 ++++++++++
 1 files changed

// File: rtl/adder_seq_ctrl.sv
// Wide add/subtract built from one 4-bit add-with-carry slice,
// iterated LSB nibble first, one nibble per clock.
module adder_seq_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   sub,
  input  logic [4*NIBBLES-1:0]   op_a,
  input  logic [4*NIBBLES-1:0]   op_b,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   result,
  output logic                   cout,
  output logic                   ovf
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [W-1:0]    a_r;
  logic [W-1:0]    b_r;
  logic            sub_r;
  logic [IW-1:0]   idx;
  logic            carry;
  logic [W-1:0]    part;

  logic [3:0]      an;
  logic [3:0]      bn;
  logic [4:0]      sum;
  logic [W-1:0]    part_n;
  logic [5:0]      sh;
  logic            last;
  logic            ovf_n;

  always_comb begin
    sh     = 6'({idx, 2'b00});
    an     = 4'(a_r >> sh);
    bn     = 4'(b_r >> sh) ^ {4{sub_r}};
    sum    = {1'b0, an} + {1'b0, bn} + {4'b0, carry};
    part_n = (part & ~(W'(4'hF) << sh))
           | (W'(sum[3:0]) << sh);
    last   = (idx == IW'(NIBBLES - 1));
    // B msb after the subtract inversion
    ovf_n  = (a_r[W-1] == (b_r[W-1] ^ sub_r))
          && (part_n[W-1] != a_r[W-1]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a_r    <= '0;
      b_r    <= '0;
      sub_r  <= 1'b0;
      idx    <= '0;
      carry  <= 1'b0;
      part   <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            a_r   <= op_a;
            b_r   <= op_b;
            sub_r <= sub;
            idx   <= '0;
            carry <= sub;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          part  <= part_n;
          carry <= sum[4];
          if (last) begin
            idx    <= '0;
            busy   <= 1'b0;
            done   <= 1'b1;
            result <= part_n;
            cout   <= sum[4];
            ovf    <= ovf_n;
            state  <= DONE;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
